// File: rtl/register_bank_arbiter.sv
// -----------------------------------------------------------------------------
// register_bank_arbiter
//
// Purpose:
//   One bank of 2**ADDR_WIDTH configuration registers shared by NUM_REQ write
//   requesters. Writes are granted round-robin through a two-state FSM
//   (IDLE -> GRANT). A separate registered read port serves the datapath.
//
// Optional feature (macro REGISTER_BANK_ARBITER_LOCK_EN):
//   Adds input req_lock. A locked winner stays in GRANT after each commit.
//   This gives one write per cycle for atomic multi-register updates.
//
// Ports:
//   clock      : sole clock, rising edge
//   reset      : asynchronous active-low reset
//   req_valid  : per-requester write request
//   req_addr   : packed write addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   : packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_lock   : (LOCK_EN only) hold the grant across consecutive commits
//   req_ready  : registered one-hot write accept
//   grant_id   : index of the requester that last completed a transfer
//   wr_strobe  : one-cycle pulse in the cycle after a committed write
//   wr_addr_o  : address of the last committed write
//   rd_en      : read request
//   rd_addr    : read index
//   rd_data    : read data, registered, holds when rd_en is low
//   rd_valid   : high exactly one cycle after rd_en
//   dbg_state  : current FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake:
//   A write transfer happens on the rising edge where req_valid[i] and
//   req_ready[i] are both high. req_ready is registered and is high for at
//   most one requester. A requester holds valid, address and data stable
//   until it sees req_ready. If valid drops while the requester is granted,
//   that is a withdrawal: nothing is written and the pointer keeps its value.
// -----------------------------------------------------------------------------
module register_bank_arbiter #(
  parameter int                    NUM_REQ     = 4,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
`ifdef REGISTER_BANK_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]                   req_lock,
`endif
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 wr_strobe,
  output logic [ADDR_WIDTH-1:0]                wr_addr_o,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_valid,
  output logic                                 dbg_state
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ID_W-1:0]        r_winner;
  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        w_pick;
  logic [ID_W-1:0]        w_ptr_inc;
  logic [ID_W:0]          w_cand;
  logic                   w_found;
  logic [NUM_REQ-1:0]     r_ready;
  logic [NUM_REQ-1:0]     w_ready_next;
  logic                   w_commit;
  logic                   w_win_valid;
  logic                   w_win_lock;
  logic [ID_W-1:0]        r_grant_id;
  logic                   r_wr_strobe;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [DATA_WIDTH-1:0]  r_rd_data;
  logic                   r_rd_valid;
  logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  w_data_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  r_bank     [DEPTH];

  // Unpack the flat request buses so the winner can be indexed directly.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: scan upward from r_ptr and wrap modulo NUM_REQ.
  // The extra bit in w_cand holds ptr+k before the wrap subtraction.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      end
      if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[ID_W-1:0];
      end
    end
  end

  assign w_win_valid = req_valid[r_winner];
`ifdef REGISTER_BANK_ARBITER_LOCK_EN
  assign w_win_lock  = req_lock[r_winner];
`else
  assign w_win_lock  = 1'b0;
`endif
  assign w_ptr_inc   = (r_winner == ID_W'(NUM_REQ-1)) ? '0 : r_winner + 1'b1;

  // FSM next state and the registered one-hot ready.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_ready_next = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next         = S_GRANT;
          w_ready_next[w_pick] = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_win_valid) begin
          w_commit = 1'b1;
          if (w_win_lock) begin
            // A locked winner keeps its grant for the next cycle.
            w_ready_next = r_ready;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ready     <= '0;
      r_winner    <= '0;
      r_ptr       <= '0;
      r_grant_id  <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_ready     <= w_ready_next;
      r_wr_strobe <= w_commit;
      if (r_state == S_IDLE && w_found) begin
        r_winner <= w_pick;
      end
      if (w_commit) begin
        r_grant_id <= r_winner;
        r_wr_addr  <= w_addr_arr[r_winner];
        if (!w_win_lock) begin
          r_ptr <= w_ptr_inc;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= RESET_VALUE;
      end
    end else if (w_commit) begin
      r_bank[w_addr_arr[r_winner]] <= w_data_arr[r_winner];
    end
  end

  // The read samples the bank before this edge's write lands, so a read and
  // a write to the same address on the same edge return the old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= r_bank[rd_addr];
      end
    end
  end

  assign req_ready = r_ready;
  assign grant_id  = r_grant_id;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr_o = r_wr_addr;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_register_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_register_bank_arbiter
//
// Self-checking bench for register_bank_arbiter (NUM_REQ=4, DATA_WIDTH=32,
// ADDR_WIDTH=4, RESET_VALUE=0). A reference model holds the bank contents,
// the round-robin pointer and the pending winner. Each step predicts the
// outputs for the next edge. The model then compares them with the DUT one
// nanosecond after that edge. Read results go through an expected queue.
// -----------------------------------------------------------------------------
module tb_register_bank_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_data  = '0;
`ifdef REGISTER_BANK_ARBITER_LOCK_EN
  logic [N-1:0]    req_lock  = '0;
`endif
  logic [N-1:0]    req_ready;
  logic [IDW-1:0]  grant_id;
  logic            wr_strobe;
  logic [AW-1:0]   wr_addr_o;
  logic            rd_en     = 1'b0;
  logic [AW-1:0]   rd_addr   = '0;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            dbg_state;

  register_bank_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_VALUE('0)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
`ifdef REGISTER_BANK_ARBITER_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .grant_id(grant_id),
    .wr_strobe(wr_strobe), .wr_addr_o(wr_addr_o),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .dbg_state(dbg_state)
  );

  // requester-side intent
  bit            v [N];
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  // reference model and scoreboard
  logic [DW-1:0]  m_bank [DEPTH];
  int             m_ptr;
  int             m_win;
  logic [DW-1:0]  m_rd;
  logic [IDW-1:0] m_gid;
  logic [DW-1:0]  exp_q [$];
  int             wait_cnt [N];
  int             n_cmp;
  int             n_fail;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      wait_cnt[i] = 0;
    end
    m_ptr = 0;
    m_win = -1;
    m_rd  = '0;
    m_gid = '0;
    exp_q.delete();
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_addr[i*AW +: AW]  = a[i];
      req_data[i*DW +: DW]  = d[i];
    end
  endtask

  // First valid requester at or after the pointer, wrapping around.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Drive current intent, predict the next edge, clock it, and compare.
  task automatic step(output int committed);
    logic [N-1:0]  exp_ready;
    logic          exp_strobe;
    logic [AW-1:0] exp_waddr;
    logic          exp_rv;
    apply();
    committed  = -1;
    exp_ready  = '0;
    exp_strobe = 1'b0;
    exp_waddr  = '0;
    exp_rv     = rd_en;
    if (rd_en) exp_q.push_back(m_bank[rd_addr]);
    if (m_win < 0) begin
      m_win = pick();
      if (m_win >= 0) exp_ready[m_win] = 1'b1;
    end else begin
      if (v[m_win]) begin
        m_bank[a[m_win]] = d[m_win];
        m_ptr      = (m_win + 1) % N;
        m_gid      = IDW'(m_win);
        exp_strobe = 1'b1;
        exp_waddr  = a[m_win];
        committed  = m_win;
      end
      m_win = -1;
    end
    @(posedge clock);
    #1;
    chk("req_ready", DW'(req_ready), DW'(exp_ready));
    chk("wr_strobe", DW'(wr_strobe), DW'(exp_strobe));
    chk("grant_id", DW'(grant_id), DW'(m_gid));
    chk("rd_valid", DW'(rd_valid), DW'(exp_rv));
    if (exp_strobe) chk("wr_addr_o", DW'(wr_addr_o), DW'(exp_waddr));
    if (exp_rv) m_rd = exp_q.pop_front();
    chk("rd_data", rd_data, m_rd);
  endtask

  initial begin
    int c;
    int start;
    int gcount;
    int g;
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    model_reset();

    // reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", DW'(req_ready), 0);
    chk("rst_grant_id", DW'(grant_id), 0);
    chk("rst_wr_strobe", DW'(wr_strobe), 0);
    chk("rst_wr_addr", DW'(wr_addr_o), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", DW'(rd_valid), 0);
    reset = 1'b1;

    // reset while requester 1 is granted: the write is discarded
    v[1] = 1'b1; a[1] = 4'd7; d[1] = 32'hDEADBEEF;
    step(c);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_ready", DW'(req_ready), 0);
    v[1] = 1'b0;
    apply();
    @(posedge clock);
    #1;
    chk("rst_hold_ready", DW'(req_ready), 0);
    chk("rst_hold_strobe", DW'(wr_strobe), 0);
    reset = 1'b1;
    model_reset();
    rd_en = 1'b1; rd_addr = 4'd7;
    step(c);
    chk("rst_bank7", rd_data, 0);
    rd_en = 1'b0;
    step(c);

    // single write: requester 2, addr 3
    v[2] = 1'b1; a[2] = 4'd3; d[2] = 32'h12345678;
    step(c);
    chk("single_ready", DW'(req_ready), 32'h4);
    step(c);
    chk("single_gid", DW'(grant_id), 2);
    chk("single_waddr", DW'(wr_addr_o), 3);
    v[2] = 1'b0;
    step(c);
    rd_en = 1'b1; rd_addr = 4'd3;
    step(c);
    chk("single_rd", rd_data, 32'h12345678);
    rd_en = 1'b0;

    // withdrawal: pointer is 3, requester 1 wins and then drops valid
    v[1] = 1'b1; a[1] = 4'd9;  d[1] = 32'h11111111;
    v[2] = 1'b1; a[2] = 4'd10; d[2] = 32'h22222222;
    step(c);
    chk("wd_ready1", DW'(req_ready), 32'h2);
    v[1] = 1'b0;
    step(c);
    chk("wd_no_strobe", DW'(wr_strobe), 0);
    step(c);
    chk("wd_next_ready", DW'(req_ready), 32'h4);
    step(c);
    v[2] = 1'b0;

    // collision: write addr 5 while reading addr 5 on the same edge
    v[0] = 1'b1; a[0] = 4'd5; d[0] = 32'hA5A5A5A5;
    step(c);
    rd_en = 1'b1; rd_addr = 4'd5;
    step(c);
    chk("coll_old", rd_data, 0);
    v[0] = 1'b0;
    step(c);
    chk("coll_new", rd_data, 32'hA5A5A5A5);
    rd_en = 1'b0;

    // round-robin: everyone holds valid, each writes its index to addr 0
    start  = m_ptr;
    gcount = 0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; a[i] = '0; d[i] = DW'(i);
    end
    for (int s = 0; s < 40 && gcount < 10; s++) begin
      step(c);
      if (wr_strobe) begin
        chk("rr_order", DW'(grant_id), DW'((start + gcount) % N));
        gcount++;
      end
    end
    chk("rr_count", DW'(gcount), 10);
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    rd_en = 1'b1; rd_addr = '0;
    step(c);
    chk("rr_final", rd_data, DW'((start + 9) % N));
    rd_en = 1'b0;
    step(c);

    // randomized traffic, withdrawals and reads
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && i != m_win && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          a[i] = AW'($urandom_range(0, DEPTH-1));
          d[i] = $urandom;
          wait_cnt[i] = 0;
        end
      end
      if (m_win >= 0 && $urandom_range(0, 7) == 0) v[m_win] = 1'b0;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, DEPTH-1));
      step(c);
      if (wr_strobe) begin
        g = int'(grant_id);
        for (int i = 0; i < N; i++) begin
          if (i == g) begin
            wait_cnt[i] = 0;
          end else if (v[i]) begin
            wait_cnt[i]++;
            chk("fair_wait", DW'(wait_cnt[i] <= N), 1);
          end
        end
      end
      if (c >= 0) v[c] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank_arbiter.md
Name: register_bank_arbiter

Overview:
- Shares one bank of 2**ADDR_WIDTH configuration registers between NUM_REQ write requesters.
- Write access is granted round-robin over a valid/ready handshake.
- Provides one registered read port for the datapath.
- Sits between the control-plane masters (AXI-lite bridge, sequencers, calibration FSMs) and the datapath configuration registers. The bank replaces scattered single-register instances with one arbitrated resource.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 4, register index width; bank depth = 2**ADDR_WIDTH.
- RESET_VALUE, 0, value loaded into every bank entry on reset.

Ports:
- clock  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset: asserted at 0, released synchronously to clock by the system reset bridge.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed write addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  packed write data; same slicing scheme.
- req_ready  output  NUM_REQ  one-hot write accept; a transfer occurs when req_valid[i] & req_ready[i].
- grant_id  output  clog2(NUM_REQ)  index of the requester that last completed a transfer.
- wr_strobe  output  1  single-cycle pulse one cycle after any committed write.
- wr_addr_o  output  ADDR_WIDTH  address of the last committed write; valid with wr_strobe.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read index.
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  high exactly one cycle after rd_en.

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - all bank entries = RESET_VALUE; req_ready = 0; grant_id = 0; wr_strobe = 0; wr_addr_o = 0; rd_data = 0; rd_valid = 0.
  - Round-robin pointer = 0; FSM = IDLE.
  - A write in flight during reset is discarded.
- FSM states and transitions:
  - IDLE: req_ready = 0. If any req_valid is high, select the winner by scanning from pointer upward (wrapping modulo NUM_REQ), latch the winner index, go to GRANT.
  - GRANT: req_ready[winner] = 1 (registered, one-hot).
    - If req_valid[winner] is still high: bank[req_addr[winner]] <= req_data[winner]; pointer <= winner+1 (wraps to 0 after NUM_REQ-1); grant_id <= winner; go to IDLE.
    - If req_valid[winner] has dropped (requester withdrew): no write, pointer unchanged, go to IDLE.
- Throughput and latency:
  - One write per 2 cycles.
  - Latency from req_valid rising to the write committing: 2 clocks.
  - wr_strobe and wr_addr_o assert on the cycle after the write commits.
- Requester rules:
  - A requester must hold req_valid, addr and data stable until it sees req_ready.
  - req_ready is never asserted to more than one requester.
  - No requester waits more than NUM_REQ grants.
- Read port:
  - rd_en at edge N gives rd_data = bank[rd_addr] and rd_valid = 1 at edge N+1.
  - With rd_en = 0, rd_data holds its last value and rd_valid = 0.
- Read/write collision: a read and a write to the same address on the same edge return the OLD value (read-before-write). The new value is visible on the next read.
- Width rules: addresses are used directly, with no range check (the full 2**ADDR_WIDTH range is legal). Data is stored unmodified.

Optional Feature:
- Macro: REGISTER_BANK_ARBITER_LOCK_EN.
- When defined:
  - Adds input req_lock [NUM_REQ].
  - If req_lock[winner] is high at commit, the FSM skips IDLE: it stays in GRANT with the same winner and the pointer does not advance. This gives back-to-back writes, one per cycle, for atomic multi-register updates.
  - The lock releases on the first commit with req_lock low, or when req_valid drops.
- When undefined: no req_lock port; behaviour exactly as above.

Test Plan:
- Reset value: assert reset=0 mid-GRANT with req_valid[1]=1, data 0xDEADBEEF -> bank is not written; read of any address returns RESET_VALUE (0); req_ready = 0.
- Single write: requester 2 writes addr 3, data 0x12345678 -> req_ready[2] high 1 cycle after valid; wr_strobe one cycle after commit with wr_addr_o=3; grant_id=2; rd_en addr 3 returns 0x12345678 with rd_valid one cycle later.
- Round-robin fairness: all 4 requesters hold valid continuously, each writing its own index to addr 0 -> grant order 0,1,2,3,0; addr 0 final value sequence matches; no requester waits more than 4 grants.
- Withdrawal: requester 1 drops valid in GRANT -> no write, wr_strobe stays 0, pointer unchanged, next grant goes to the next valid requester.
- Collision: write addr 5 = 0xA5A5A5A5 (old value 0) while reading addr 5 on the same edge -> rd_data=0; re-read next cycle -> 0xA5A5A5A5.
- Lock (LOCK_EN defined): requester 0 holds lock for 3 writes to addrs 0,1,2 while requester 3 is valid -> three consecutive single-cycle commits by requester 0, then requester 3 is granted.
